perceptron_sum_stage: RTL

- Stage directly downstream of the perceptron weight table, clocked by the same fire strobe.
- Each accepted transaction carries four weight vectors, one per branch slot of a fetch block, plus the 8-bit global history.
- For each slot the block computes the signed perceptron dot product: weights times history as ±1, plus the bias.
- Per slot it emits taken/not-taken, the sum, and a low-confidence flag that the training path uses to decide on weight update.
- Two-stage valid/ready pipeline with flush on misprediction.

---
 rtl/perceptron_sum_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/perceptron_sum_stage.sv
// Perceptron sum stage: per-slot signed dot product of weights with +/-1 history plus bias,
// in a two-stage valid/ready pipeline that can be flushed on a misprediction.
module perceptron_sum_stage #(
   parameter int THETA = 29
) (
   input  logic         i_fire,
   input  logic         rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [287:0] i_weights_288,
   input  logic [7:0]   i_ghr_8,
   input  logic         i_flush,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [3:0]   o_predict_4,
   output logic [47:0]  o_sums_48,
   output logic [3:0]   o_lowConf_4,
   output logic [7:0]   o_ghr_8
);

   localparam logic signed [12:0] THETA_POS = 13'(THETA);
   localparam logic signed [12:0] THETA_NEG = -THETA_POS;

   logic       s1_valid_reg;
   logic       s2_valid_reg;
   logic [7:0] s1_ghr_reg;
   logic [7:0] s2_ghr_reg;

   logic s2_accept;
   logic s1_advance;
   logic s1_load;
   logic s2_load;

   // Handshake is purely combinational so a downstream stall propagates back in the same cycle.
   always_comb begin
      s2_accept  = !s2_valid_reg || i_ready;
      s1_advance = s1_valid_reg && s2_accept;
      o_ready    = (!s1_valid_reg || s2_accept) && !i_flush;
      s1_load    = i_valid && o_ready;
      s2_load    = s1_advance && !i_flush;
   end

   always_ff @(posedge i_fire or negedge rst) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s1_ghr_reg   <= '0;
         s2_ghr_reg   <= '0;
      end else if (i_flush) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid_reg <= 1'b1;
            s1_ghr_reg   <= i_ghr_8;
         end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
         end

         if (s2_load) begin
            s2_valid_reg <= 1'b1;
            s2_ghr_reg   <= s1_ghr_reg;
         end else if (i_ready) begin
            s2_valid_reg <= 1'b0;
         end
      end
   end

   assign o_valid = s2_valid_reg;
   assign o_ghr_8 = s2_ghr_reg;

   genvar gi, gj;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot
         logic signed [11:0] term [8];
         logic signed [11:0] bias_ext;
         logic signed [11:0] part_a_next;
         logic signed [11:0] part_b_next;
         logic signed [11:0] s1_part_a_reg;
         logic signed [11:0] s1_part_b_reg;
         logic signed [11:0] sum_next;
         logic signed [12:0] sum_wide;
         logic               lowconf_next;
         logic signed [11:0] s2_sum_reg;
         logic               s2_predict_reg;
         logic               s2_lowconf_reg;

         // A zero history bit negates the weight; 12 bits leave room for +128.
         for (gj = 0; gj < 8; gj++) begin : g_term
            logic [7:0]         w;
            logic signed [11:0] w_ext;
            assign w       = i_weights_288[gi*72 + gj*8 +: 8];
            assign w_ext   = {{4{w[7]}}, w};
            assign term[gj] = i_ghr_8[gj] ? w_ext : -w_ext;
         end

         assign bias_ext    = {{4{i_weights_288[gi*72 + 71]}}, i_weights_288[gi*72 + 64 +: 8]};
         assign part_a_next = term[0] + term[1] + term[2] + term[3];
         assign part_b_next = term[4] + term[5] + term[6] + term[7] + bias_ext;

         assign sum_next     = s1_part_a_reg + s1_part_b_reg;
         assign sum_wide     = {sum_next[11], sum_next};
         assign lowconf_next = (sum_wide >= THETA_NEG) && (sum_wide <= THETA_POS);

         always_ff @(posedge i_fire or negedge rst) begin
            if (!rst) begin
               s1_part_a_reg  <= '0;
               s1_part_b_reg  <= '0;
               s2_sum_reg     <= '0;
               s2_predict_reg <= 1'b0;
               s2_lowconf_reg <= 1'b0;
            end else begin
               if (s1_load) begin
                  s1_part_a_reg <= part_a_next;
                  s1_part_b_reg <= part_b_next;
               end
               if (s2_load) begin
                  s2_sum_reg     <= sum_next;
                  s2_predict_reg <= ~sum_next[11];
                  s2_lowconf_reg <= lowconf_next;
               end
            end
         end

         assign o_sums_48[gi*12 +: 12] = s2_sum_reg;
         assign o_predict_4[gi]        = s2_predict_reg;
         assign o_lowConf_4[gi]        = s2_lowconf_reg;
      end
   endgenerate

endmodule
